// File: rtl/mul_share_pkg.sv
// rtl/mul_share_pkg.sv - shared types and helpers for the shared-multiplier arbiter
package mul_share_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        RESP = 2'd2
    } state_t;

    // A single requester still needs a one-bit ID field.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mul_share_arb_if.sv
// rtl/mul_share_arb_if.sv - request/response bus between clients and the shared multiplier
interface mul_share_arb_if #(
    parameter int N    = 8,
    parameter int NREQ = 4
);
    import mul_share_pkg::*;

    localparam int IW = id_width(NREQ);

    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*N-1:0] req_a;
    logic [NREQ*N-1:0] req_b;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [2*N-1:0]    rsp_y;
    logic [IW-1:0]     rsp_id;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_y, rsp_id
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_y, rsp_id
    );

endinterface

// File: rtl/mulN.sv
// rtl/mulN.sv - N x N unsigned combinational array multiplier
module mulN #(
    parameter int N = 8
) (
    input  logic [N-1:0]   i_a,
    input  logic [N-1:0]   i_b,
    output logic [2*N-1:0] o_y
);

    logic [2*N-1:0] w_acc;

    always_comb begin
        w_acc = '0;
        for (int i = 0; i < N; i++) begin
            if (i_b[i]) begin
                w_acc = w_acc + ({{N{1'b0}}, i_a} << i);
            end
        end
        o_y = w_acc;
    end

endmodule

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker (rotate, priority-encode, rotate back)
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IW   = 2
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IW-1:0]   i_ptr,
    output logic [NREQ-1:0] o_gnt_onehot,
    output logic [IW-1:0]   o_gnt_idx,
    output logic            o_any
);

    logic [NREQ-1:0] w_rot;
    logic            w_found;
    int              w_sel;

    always_comb begin
        w_rot        = '0;
        w_found      = 1'b0;
        w_sel        = 0;
        o_gnt_onehot = '0;
        // Position 0 of the rotated vector is the requester at i_ptr.
        for (int j = 0; j < NREQ; j++) begin
            w_rot[j] = i_req[IW'((j + int'(i_ptr)) % NREQ)];
        end
        for (int j = 0; j < NREQ; j++) begin
            if (!w_found && w_rot[j]) begin
                w_found = 1'b1;
                w_sel   = j;
            end
        end
        o_gnt_idx = IW'((w_sel + int'(i_ptr)) % NREQ);
        if (w_found) begin
            o_gnt_onehot[o_gnt_idx] = 1'b1;
        end
        o_any = w_found;
    end

endmodule

// File: rtl/mul_share_arb.sv
// rtl/mul_share_arb.sv - round-robin sharing of one registered-operand multiplier among NREQ clients
module mul_share_arb
    import mul_share_pkg::*;
#(
    parameter int N    = 8,
    parameter int NREQ = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    mul_share_arb_if.slave      bus,
    output logic                busy
);

    localparam int IW = id_width(NREQ);

    state_t          r_state, w_state_nxt;
    logic [IW-1:0]   r_rr_ptr, r_id, r_rsp_id, w_gnt_idx, w_ptr_nxt;
    logic [N-1:0]    r_op_a, r_op_b, w_sel_a, w_sel_b;
    logic [2*N-1:0]  w_prod, r_rsp_y;
    logic            r_rsp_valid, w_any, w_accept;
    logic [NREQ-1:0] w_gnt_onehot;

    rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
        .i_req        (bus.req_valid),
        .i_ptr        (r_rr_ptr),
        .o_gnt_onehot (w_gnt_onehot),
        .o_gnt_idx    (w_gnt_idx),
        .o_any        (w_any)
    );

    mulN #(.N(N)) u_mul (
        .i_a (r_op_a),
        .i_b (r_op_b),
        .o_y (w_prod)
    );

    always_comb begin
        w_sel_a = '0;
        w_sel_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_gnt_onehot[i]) begin
                w_sel_a = bus.req_a[i*N +: N];
                w_sel_b = bus.req_b[i*N +: N];
            end
        end
    end

    assign w_ptr_nxt = (w_gnt_idx == IW'(NREQ - 1)) ? '0 : w_gnt_idx + IW'(1);

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_accept    = 1'b1;
                    w_state_nxt = MUL;
                end
            end
            MUL:  w_state_nxt = RESP;
            RESP: begin
                if (bus.rsp_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr    <= '0;
            r_id        <= '0;
            r_op_a      <= '0;
            r_op_b      <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_y     <= '0;
            r_rsp_id    <= '0;
        end else begin
            if (w_accept) begin
                r_op_a   <= w_sel_a;
                r_op_b   <= w_sel_b;
                r_id     <= w_gnt_idx;
                r_rr_ptr <= w_ptr_nxt;
            end
            if (r_state == MUL) begin
                r_rsp_y     <= w_prod;
                r_rsp_id    <= r_id;
                r_rsp_valid <= 1'b1;
            end
            if (r_state == RESP && bus.rsp_ready) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

    // Grants are suppressed during reset even though req_valid may already be up.
    assign bus.req_ready = (r_state == IDLE && rst_n) ? w_gnt_onehot : '0;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_y     = r_rsp_y;
    assign bus.rsp_id    = r_rsp_id;
    assign busy          = (r_state != IDLE);

endmodule

// File: tb/tb_mul_share_arb.sv
// tb/tb_mul_share_arb.sv - self-checking bench for mul_share_arb
`timescale 1ns/1ps
module tb_mul_share_arb;

    localparam int N    = 8;
    localparam int NREQ = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy;

    always #5 clk = ~clk;

    mul_share_arb_if #(.N(N), .NREQ(NREQ)) bus ();

    mul_share_arb #(.N(N), .NREQ(NREQ)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .busy  (busy)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] rand_op();
        case ($urandom % 5)
            0:       return 8'h00;
            1:       return 8'hFF;
            default: return 8'($urandom);
        endcase
    endfunction

    task automatic drive_idle();
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        drive_idle();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One transaction with rsp_ready held high; non-granted requesters get random operands.
    task automatic run_txn(input logic [3:0] mask, input int g, input logic [7:0] a,
                           input logic [7:0] b, input logic [15:0] y, input string tag);
        @(negedge clk);
        bus.rsp_ready = 1'b1;
        bus.req_valid = mask;
        for (int i = 0; i < NREQ; i++) begin
            bus.req_a[i*N +: N] = (i == g) ? a : 8'($urandom);
            bus.req_b[i*N +: N] = (i == g) ? b : 8'($urandom);
        end
        #1;
        check({tag, " req_ready"}, 32'(bus.req_ready), 32'(1 << g));
        check({tag, " busy idle"}, 32'(busy), 32'd0);
        @(negedge clk);
        bus.req_valid = '0;
        check({tag, " busy mul"}, 32'(busy), 32'd1);
        check({tag, " rsp_valid early"}, 32'(bus.rsp_valid), 32'd0);
        @(negedge clk);
        check({tag, " rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
        check({tag, " rsp_y"}, 32'(bus.rsp_y), 32'(y));
        check({tag, " rsp_id"}, 32'(bus.rsp_id), 32'(g));
        @(negedge clk);
        check({tag, " rsp_valid done"}, 32'(bus.rsp_valid), 32'd0);
        check({tag, " busy done"}, 32'(busy), 32'd0);
    endtask

    typedef struct {
        int          id;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] y;
    } vec_t;

    vec_t vecs[7];

    logic [3:0]  rv;
    logic [7:0]  ra[NREQ];
    logic [7:0]  rb[NREQ];
    int          m_ptr, m_age, m_id, exp_g, idx;
    bit          m_inflight;
    logic [15:0] m_y;

    initial begin
        vecs[0] = '{2, 8'hFF, 8'hFF, 16'hFE01};
        vecs[1] = '{0, 8'h00, 8'hAB, 16'h0000};
        vecs[2] = '{1, 8'h80, 8'h02, 16'h0100};
        vecs[3] = '{3, 8'h01, 8'hFF, 16'h00FF};
        vecs[4] = '{0, 8'hFF, 8'h00, 16'h0000};
        vecs[5] = '{1, 8'h0C, 8'h0D, 16'h009C};
        vecs[6] = '{3, 8'h10, 8'h0F, 16'h00F0};

        // Reset state, with every requester already asking.
        drive_idle();
        bus.req_valid = 4'hF;
        repeat (2) @(negedge clk);
        #1;
        check("reset req_ready", 32'(bus.req_ready), 32'd0);
        check("reset rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("reset rsp_y", 32'(bus.rsp_y), 32'd0);
        check("reset rsp_id", 32'(bus.rsp_id), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        @(negedge clk);
        drive_idle();
        rst_n = 1'b1;

        for (int v = 0; v < 7; v++) begin
            run_txn(4'(1 << vecs[v].id), vecs[v].id, vecs[v].a, vecs[v].b, vecs[v].y, "vec");
        end

        // Fairness with all four requesters held valid.
        pulse_reset();
        @(negedge clk);
        bus.rsp_ready = 1'b1;
        bus.req_valid = 4'hF;
        for (int i = 0; i < NREQ; i++) begin
            bus.req_a[i*N +: N] = 8'(i + 1);
            bus.req_b[i*N +: N] = 8'd10;
        end
        for (int k = 0; k < 5; k++) begin
            #1;
            check("fair grant", 32'(bus.req_ready), 32'(1 << (k % 4)));
            @(negedge clk);
            check("fair ready mul", 32'(bus.req_ready), 32'd0);
            @(negedge clk);
            check("fair ready resp", 32'(bus.req_ready), 32'd0);
            check("fair rsp_y", 32'(bus.rsp_y), 32'(((k % 4) + 1) * 10));
            check("fair rsp_id", 32'(bus.rsp_id), 32'(k % 4));
            @(negedge clk);
        end
        bus.req_valid = '0;

        // Backpressure: response must hold while rsp_ready is low.
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        bus.req_valid = 4'b0010;
        bus.req_a[1*N +: N] = 8'd12;
        bus.req_b[1*N +: N] = 8'd13;
        #1;
        check("bp grant", 32'(bus.req_ready), 32'b0010);
        @(negedge clk);
        bus.req_valid = 4'b0001;
        bus.req_a[0 +: N] = 8'd3;
        bus.req_b[0 +: N] = 8'd5;
        #1;
        check("bp ready mul", 32'(bus.req_ready), 32'd0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp rsp_valid", 32'(bus.rsp_valid), 32'd1);
            check("bp rsp_y", 32'(bus.rsp_y), 32'd156);
            check("bp rsp_id", 32'(bus.rsp_id), 32'd1);
            check("bp ready held", 32'(bus.req_ready), 32'd0);
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        check("bp next grant", 32'(bus.req_ready), 32'b0001);
        check("bp rsp_valid low", 32'(bus.rsp_valid), 32'd0);
        @(negedge clk);
        bus.req_valid = '0;
        @(negedge clk);
        check("bp second rsp_y", 32'(bus.rsp_y), 32'd15);
        check("bp second rsp_id", 32'(bus.rsp_id), 32'd0);
        @(negedge clk);

        // Pointer skip and wrap, starting from rr_ptr=1.
        run_txn(4'b0100, 2, 8'd7, 8'd9, 16'd63, "skip a");
        run_txn(4'b0010, 1, 8'h11, 8'h22, 16'h0242, "skip b");
        run_txn(4'b1111, 2, 8'd5, 8'd6, 16'd30, "skip c");
        run_txn(4'b1000, 3, 8'hFF, 8'h02, 16'h01FE, "wrap a");
        run_txn(4'b1111, 0, 8'h10, 8'h10, 16'h0100, "wrap b");

        // Reset asserted during MUL abandons the transaction.
        @(negedge clk);
        bus.req_valid = 4'b0100;
        bus.req_a[2*N +: N] = 8'hAA;
        bus.req_b[2*N +: N] = 8'h55;
        #1;
        check("rst grant", 32'(bus.req_ready), 32'b0100);
        @(negedge clk);
        bus.req_valid = 4'b1000;
        #2;
        rst_n = 1'b0;
        #1;
        check("rst async busy", 32'(busy), 32'd0);
        check("rst async rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst async rsp_y", 32'(bus.rsp_y), 32'd0);
        check("rst async req_ready", 32'(bus.req_ready), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        bus.req_valid = '0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("rst no rsp", 32'(bus.rsp_valid), 32'd0);
        end
        run_txn(4'b1111, 0, 8'd3, 8'd3, 16'd9, "rst after");

        // Randomized traffic against a transaction-level model.
        pulse_reset();
        rv = '0;
        m_ptr = 0;
        m_inflight = 1'b0;
        m_age = 0;
        m_id = 0;
        m_y = '0;
        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            for (int i = 0; i < NREQ; i++) begin
                if (!rv[i]) begin
                    if ($urandom % 3 == 0) begin
                        rv[i] = 1'b1;
                        ra[i] = rand_op();
                        rb[i] = rand_op();
                    end
                end else if ($urandom % 16 == 0) begin
                    rv[i] = 1'b0;
                end
                bus.req_a[i*N +: N] = ra[i];
                bus.req_b[i*N +: N] = rb[i];
            end
            bus.req_valid = rv;
            bus.rsp_ready = ($urandom % 3 != 0);
            #1;
            exp_g = -1;
            if (!m_inflight) begin
                for (int k = 0; k < NREQ; k++) begin
                    idx = (m_ptr + k) % NREQ;
                    if (rv[idx] && exp_g < 0) exp_g = idx;
                end
            end
            check("rnd req_ready", 32'(bus.req_ready), (exp_g >= 0) ? 32'(1 << exp_g) : 32'd0);
            check("rnd busy", 32'(busy), 32'(m_inflight));
            check("rnd rsp_valid", 32'(bus.rsp_valid), 32'(m_inflight && m_age >= 2));
            if (m_inflight && m_age >= 2) begin
                check("rnd rsp_y", 32'(bus.rsp_y), 32'(m_y));
                check("rnd rsp_id", 32'(bus.rsp_id), 32'(m_id));
            end
            if (!m_inflight) begin
                if (exp_g >= 0) begin
                    m_inflight = 1'b1;
                    m_age = 1;
                    m_id = exp_g;
                    m_y = {8'h00, ra[exp_g]} * {8'h00, rb[exp_g]};
                    m_ptr = (exp_g + 1) % NREQ;
                    rv[exp_g] = 1'b0;
                end
            end else if (m_age >= 2 && bus.rsp_ready) begin
                m_inflight = 1'b0;
            end else begin
                m_age++;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
